// File: rtl/seven_segment_pkg.sv
// Shared definitions for the multiplexed seven-segment display driver.
//
// Contents:
//   SEG_A .. SEG_DP  bit positions inside the 8-bit pattern {dp,g,f,e,d,c,b,a}
//   glyph_table()    constant function building the 16-entry active-high hex glyph table
//   GLYPH_TABLE      the table itself, evaluated at elaboration
//   hex_glyph(n)     7-bit active-high glyph {g,f,e,d,c,b,a} for nibble n (0-F)
package seven_segment_pkg;

  localparam logic [2:0] SEG_A  = 3'd0;
  localparam logic [2:0] SEG_B  = 3'd1;
  localparam logic [2:0] SEG_C  = 3'd2;
  localparam logic [2:0] SEG_D  = 3'd3;
  localparam logic [2:0] SEG_E  = 3'd4;
  localparam logic [2:0] SEG_F  = 3'd5;
  localparam logic [2:0] SEG_G  = 3'd6;
  localparam logic [2:0] SEG_DP = 3'd7;

  // Entry bit 0 is segment a, bit 6 is segment g. Lower-case b and d keep
  // them distinguishable from 8 and 0.
  function automatic logic [15:0][6:0] glyph_table();
    logic [15:0][6:0] t;
    t[4'h0] = 7'h3F;
    t[4'h1] = 7'h06;
    t[4'h2] = 7'h5B;
    t[4'h3] = 7'h4F;
    t[4'h4] = 7'h66;
    t[4'h5] = 7'h6D;
    t[4'h6] = 7'h7D;
    t[4'h7] = 7'h07;
    t[4'h8] = 7'h7F;
    t[4'h9] = 7'h6F;
    t[4'hA] = 7'h77;
    t[4'hB] = 7'h7C;
    t[4'hC] = 7'h39;
    t[4'hD] = 7'h5E;
    t[4'hE] = 7'h79;
    t[4'hF] = 7'h71;
    return t;
  endfunction

  localparam logic [15:0][6:0] GLYPH_TABLE = glyph_table();

  function automatic logic [6:0] hex_glyph(input logic [3:0] nibble);
    return GLYPH_TABLE[nibble];
  endfunction

endpackage

// File: rtl/seg_glyph_decoder.sv
// Combinational hex digit decoder.
//
// Ports:
//   nibble_i  [3:0]  hex value to display
//   dp_i             decimal point request
//   seg_o     [7:0]  active-high pattern {dp,g,f,e,d,c,b,a}
//
// Output polarity is handled by the caller.
module seg_glyph_decoder
  import seven_segment_pkg::*;
(
  input  logic [3:0] nibble_i,
  input  logic       dp_i,
  output logic [7:0] seg_o
);

  logic [6:0] glyph;

  always_comb begin
    glyph          = hex_glyph(nibble_i);
    seg_o          = 8'h00;
    seg_o[SEG_A]   = glyph[0];
    seg_o[SEG_B]   = glyph[1];
    seg_o[SEG_C]   = glyph[2];
    seg_o[SEG_D]   = glyph[3];
    seg_o[SEG_E]   = glyph[4];
    seg_o[SEG_F]   = glyph[5];
    seg_o[SEG_G]   = glyph[6];
    seg_o[SEG_DP]  = dp_i;
  end

endmodule

// File: rtl/seven_segment_mux.sv
// N-digit multiplexed seven-segment display driver.
//
// Scans one digit per slot of RefreshDiv clocks. The displayed value is taken
// from shadow registers that are reloaded only when the scan wraps back to
// digit 0, so a frame never mixes old and new input values.
//
// Ports:
//   Clk         system clock
//   Reset       synchronous, active-high reset
//   Val         digit nibbles, nibble k drives digit k (digit 0 = rightmost)
//   DpIn        decimal point request per digit
//   BlankLz     1 = suppress leading zeros (digit 0 always shown)
//   Brightness  PWM duty: anode on while pwm counter <= Brightness
//   Enable      0 = all anodes off, counters keep running
//   Seg         {dp,g,f,e,d,c,b,a}, active-low when SegActiveLow = 1
//   Seg_En      one-hot anode enable, active-low when AnActiveLow = 1
//   DigitIdx    digit currently scanned
//   FrameTick   one-cycle pulse on the cycle DigitIdx returns to 0
//
// Seg/Seg_En are registered from the current scan state, so they trail
// DigitIdx by one cycle: the first cycle of each anode slot is the dead cycle.
module seven_segment_mux
  import seven_segment_pkg::*;
#(
  parameter  int NumDigits    = 4,
  parameter  int RefreshDiv   = 50000,
  parameter  int PwmBits      = 4,
  parameter  int SegActiveLow = 1,
  parameter  int AnActiveLow  = 1,
  localparam int IdxW         = (NumDigits > 1) ? $clog2(NumDigits) : 1
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic [4*NumDigits-1:0] Val,
  input  logic [NumDigits-1:0]   DpIn,
  input  logic                   BlankLz,
  input  logic [PwmBits-1:0]     Brightness,
  input  logic                   Enable,
  output logic [7:0]             Seg,
  output logic [NumDigits-1:0]   Seg_En,
  output logic [IdxW-1:0]        DigitIdx,
  output logic                   FrameTick
);

  localparam int PrescW = $clog2(RefreshDiv);

  localparam logic [7:0]           SegOff = (SegActiveLow != 0) ? 8'hFF : 8'h00;
  localparam logic [NumDigits-1:0] AnOff  = (AnActiveLow != 0) ?
                                            {NumDigits{1'b1}} : {NumDigits{1'b0}};

  logic [PrescW-1:0]      presc_q, presc_d;
  logic [IdxW-1:0]        digit_q, digit_d;
  logic [PwmBits-1:0]     pwm_q;
  logic [4*NumDigits-1:0] shadow_val_q;
  logic [NumDigits-1:0]   shadow_dp_q;
  logic                   frame_tick_q;
  logic [7:0]             seg_q, seg_d;
  logic [NumDigits-1:0]   seg_en_q, seg_en_d;

  logic                   slot_end;
  logic                   frame_wrap;

  logic [3:0]             sel_nibble;
  logic                   sel_dp;
  logic                   sel_blank;
  logic [NumDigits-1:0]   sel_onehot;
  logic [NumDigits-1:0]   lz_mask;
  logic                   all_zero;

  logic [7:0]             glyph_seg;
  logic [7:0]             seg_ah;
  logic [NumDigits-1:0]   en_ah;
  logic                   lit;

  // --------------------------------------------------------------------------
  // Scan counters
  // --------------------------------------------------------------------------
  assign slot_end   = (presc_q == PrescW'(RefreshDiv - 1));
  assign frame_wrap = slot_end && (digit_q == IdxW'(NumDigits - 1));

  always_comb begin
    presc_d = presc_q + PrescW'(1);
    digit_d = digit_q;
    if (slot_end) begin
      presc_d = '0;
      digit_d = frame_wrap ? '0 : digit_q + IdxW'(1);
    end
  end

  // --------------------------------------------------------------------------
  // Digit selection and leading-zero mask
  // --------------------------------------------------------------------------
  // lz_mask[k] is set when shadow nibbles k..NumDigits-1 are all zero; bit 0
  // is never set so the rightmost digit always shows.
  always_comb begin
    sel_nibble = 4'h0;
    sel_dp     = 1'b0;
    sel_blank  = 1'b0;
    sel_onehot = '0;
    lz_mask    = '0;
    all_zero   = 1'b1;
    for (int k = NumDigits - 1; k >= 1; k--) begin
      all_zero   = all_zero & (shadow_val_q[4*k +: 4] == 4'h0);
      lz_mask[k] = all_zero;
    end
    for (int k = 0; k < NumDigits; k++) begin
      if (digit_q == IdxW'(k)) begin
        sel_nibble    = shadow_val_q[4*k +: 4];
        sel_dp        = shadow_dp_q[k];
        sel_onehot[k] = 1'b1;
        sel_blank     = BlankLz & lz_mask[k];
      end
    end
  end

  seg_glyph_decoder u_glyph (
    .nibble_i (sel_nibble),
    .dp_i     (sel_dp),
    .seg_o    (glyph_seg)
  );

  // --------------------------------------------------------------------------
  // Output pattern
  // --------------------------------------------------------------------------
  // The anode stays off on the first cycle of every slot so the previous
  // digit's segments never flash on the new anode.
  always_comb begin
    lit      = Enable && (presc_q != '0) && (pwm_q <= Brightness) && !sel_blank;
    seg_ah   = sel_blank ? 8'h00 : glyph_seg;
    en_ah    = lit ? sel_onehot : '0;
    seg_d    = (SegActiveLow != 0) ? ~seg_ah : seg_ah;
    seg_en_d = (AnActiveLow != 0) ? ~en_ah : en_ah;
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge Clk) begin
    if (Reset) begin
      presc_q      <= '0;
      digit_q      <= '0;
      pwm_q        <= '0;
      shadow_val_q <= '0;
      shadow_dp_q  <= '0;
      frame_tick_q <= 1'b0;
      seg_q        <= SegOff;
      seg_en_q     <= AnOff;
    end else begin
      presc_q      <= presc_d;
      digit_q      <= digit_d;
      pwm_q        <= pwm_q + PwmBits'(1);
      frame_tick_q <= frame_wrap;
      // Sample the live inputs on the wrap edge itself.
      if (frame_wrap) begin
        shadow_val_q <= Val;
        shadow_dp_q  <= DpIn;
      end
      seg_q        <= seg_d;
      seg_en_q     <= seg_en_d;
    end
  end

  assign Seg       = seg_q;
  assign Seg_En    = seg_en_q;
  assign DigitIdx  = digit_q;
  assign FrameTick = frame_tick_q;

endmodule

// File: tb/tb_seven_segment_mux.sv
module tb_seven_segment_mux;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic [15:0] Val = 16'h0000;
  logic [3:0]  DpIn = 4'h0;
  logic        BlankLz = 1'b0;
  logic [1:0]  Brightness = 2'd3;
  logic        Enable = 1'b1;
  logic [7:0]  Seg;
  logic [3:0]  Seg_En;
  logic [1:0]  DigitIdx;
  logic        FrameTick;

  int n_cmp = 0;
  int n_bad = 0;

  seven_segment_mux #(
    .NumDigits    (4),
    .RefreshDiv   (8),
    .PwmBits      (2),
    .SegActiveLow (1),
    .AnActiveLow  (1)
  ) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .Val        (Val),
    .DpIn       (DpIn),
    .BlankLz    (BlankLz),
    .Brightness (Brightness),
    .Enable     (Enable),
    .Seg        (Seg),
    .Seg_En     (Seg_En),
    .DigitIdx   (DigitIdx),
    .FrameTick  (FrameTick)
  );

  always #5 Clk = ~Clk;

  // Active-low {dp,g,f,e,d,c,b,a} patterns, worked out by hand.
  function automatic logic [7:0] glyph_al(input logic [3:0] n);
    case (n)
      4'h0: return 8'hC0;  4'h1: return 8'hF9;  4'h2: return 8'hA4;  4'h3: return 8'hB0;
      4'h4: return 8'h99;  4'h5: return 8'h92;  4'h6: return 8'h82;  4'h7: return 8'hF8;
      4'h8: return 8'h80;  4'h9: return 8'h90;  4'hA: return 8'h88;  4'hB: return 8'h83;
      4'hC: return 8'hC6;  4'hD: return 8'hA1;  4'hE: return 8'h86;  default: return 8'h8E;
    endcase
  endfunction

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Advances at least one cycle, then stops on the sample where FrameTick is
  // high (frame position j = 0: DigitIdx = 0, new shadow values in place).
  task automatic wait_frame();
    int k;
    k = 0;
    do begin
      tick();
      k++;
    end while (!FrameTick && k < 80);
    n_cmp++;
    if (FrameTick !== 1'b1) begin
      n_bad++;
      $display("FAIL wait_frame: FrameTick=%b after %0d cycles, required 1", FrameTick, k);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    int  n;
    bit  seen;
    Reset = 1'b1; Val = 16'h1234; DpIn = 4'h0; BlankLz = 1'b0; Brightness = 2'd3; Enable = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_cmp++;
      if (Seg !== 8'hFF || Seg_En !== 4'hF || DigitIdx !== 2'd0 || FrameTick !== 1'b0) begin
        n_bad++;
        $display("FAIL reset_hold: Seg=%h Seg_En=%h DigitIdx=%0d FrameTick=%b, required FF F 0 0",
                 Seg, Seg_En, DigitIdx, FrameTick);
      end
    end
    Reset = 1'b0;
    n = 0;
    seen = 0;
    while (!seen && n < 100) begin
      tick();
      n++;
      if (n == 3) begin
        n_cmp++;
        if (Seg !== 8'hC0 || Seg_En !== 4'b1110) begin
          n_bad++;
          $display("FAIL first_frame_zero: Seg=%h Seg_En=%b, required C0 1110", Seg, Seg_En);
        end
      end
      if (FrameTick === 1'b1) seen = 1;
    end
    n_cmp++;
    if (!seen || n != 32) begin
      n_bad++;
      $display("FAIL first_tick: seen=%0d after %0d cycles, required 1 after 32", seen, n);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_decode();
    logic [15:0] vals [4];
    logic [15:0] v;
    logic [7:0]  exp_seg;
    logic [3:0]  oh, exp_en;
    logic [1:0]  exp_idx;
    int d, p;
    vals[0] = 16'h1234; vals[1] = 16'hABCD; vals[2] = 16'h5678; vals[3] = 16'h09EF;
    BlankLz = 1'b0; DpIn = 4'h0; Brightness = 2'd3; Enable = 1'b1;
    for (int t = 0; t < 4; t++) begin
      v = vals[t];
      Val = v;
      wait_frame();
      for (int j = 1; j <= 32; j++) begin
        tick();
        d = (j - 1) / 8;
        p = (j - 1) % 8;
        exp_seg = glyph_al(v[4*d +: 4]);
        oh      = 4'b0001 << d;
        exp_en  = (p == 0) ? 4'hF : ~oh;
        exp_idx = (j == 32) ? 2'd0 : 2'(j / 8);
        n_cmp++;
        if (Seg !== exp_seg) begin
          n_bad++;
          $display("FAIL decode_seg val=%h j=%0d: Seg=%h, required %h", v, j, Seg, exp_seg);
        end
        n_cmp++;
        if (Seg_En !== exp_en) begin
          n_bad++;
          $display("FAIL decode_en val=%h j=%0d: Seg_En=%b, required %b", v, j, Seg_En, exp_en);
        end
        n_cmp++;
        if (DigitIdx !== exp_idx || FrameTick !== (j == 32)) begin
          n_bad++;
          $display("FAIL decode_idx j=%0d: DigitIdx=%0d FrameTick=%b, required %0d %0d",
                   j, DigitIdx, FrameTick, exp_idx, (j == 32));
        end
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_decimal_point();
    logic [7:0] exp_seg;
    logic [3:0] dp_ref;
    int d;
    Val = 16'h1234; DpIn = 4'b1010; dp_ref = 4'b1010; BlankLz = 1'b0;
    wait_frame();
    for (int j = 1; j <= 32; j++) begin
      tick();
      d = (j - 1) / 8;
      exp_seg = glyph_al(Val[4*d +: 4]) & (dp_ref[d] ? 8'h7F : 8'hFF);
      n_cmp++;
      if (Seg !== exp_seg) begin
        n_bad++;
        $display("FAIL dp_seg j=%0d: Seg=%h, required %h", j, Seg, exp_seg);
      end
      // Changing DpIn mid-frame must not show until the next frame.
      if (j == 5) DpIn = 4'b0000;
    end
    DpIn = 4'h0;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_blank_lz();
    logic [3:0] oh, exp_en;
    int d, p;
    BlankLz = 1'b1; DpIn = 4'h0; Val = 16'h0050;
    wait_frame();
    for (int j = 1; j <= 32; j++) begin
      tick();
      d = (j - 1) / 8;
      p = (j - 1) % 8;
      oh = 4'b0001 << d;
      exp_en = (p == 0 || d >= 2) ? 4'hF : ~oh;
      n_cmp++;
      if (Seg_En !== exp_en) begin
        n_bad++;
        $display("FAIL blank_0050_en j=%0d: Seg_En=%b, required %b", j, Seg_En, exp_en);
      end
      if (d < 2) begin
        n_cmp++;
        if (Seg !== ((d == 1) ? 8'h92 : 8'hC0)) begin
          n_bad++;
          $display("FAIL blank_0050_seg j=%0d: Seg=%h, required %h", j, Seg, (d == 1) ? 8'h92 : 8'hC0);
        end
      end
    end
    Val = 16'h0000;
    wait_frame();
    for (int j = 1; j <= 32; j++) begin
      tick();
      d = (j - 1) / 8;
      p = (j - 1) % 8;
      exp_en = (p == 0 || d >= 1) ? 4'hF : 4'b1110;
      n_cmp++;
      if (Seg_En !== exp_en) begin
        n_bad++;
        $display("FAIL blank_0000_en j=%0d: Seg_En=%b, required %b", j, Seg_En, exp_en);
      end
      if (d == 0) begin
        n_cmp++;
        if (Seg !== 8'hC0) begin
          n_bad++;
          $display("FAIL blank_0000_seg j=%0d: Seg=%h, required C0", j, Seg);
        end
      end
    end
    BlankLz = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_frame_latch();
    BlankLz = 1'b0; Val = 16'h1111;
    wait_frame();
    for (int j = 1; j <= 32; j++) begin
      tick();
      n_cmp++;
      if (Seg !== 8'hF9) begin
        n_bad++;
        $display("FAIL latch_hold j=%0d: Seg=%h, required F9", j, Seg);
      end
      if (j == 9) Val = 16'h2222;
    end
    // Frame of 2222; a change placed right before the wrap edge is captured.
    for (int j = 1; j <= 32; j++) begin
      tick();
      n_cmp++;
      if (Seg !== 8'hA4) begin
        n_bad++;
        $display("FAIL latch_new j=%0d: Seg=%h, required A4", j, Seg);
      end
      if (j == 31) Val = 16'h8888;
    end
    for (int j = 1; j <= 8; j++) begin
      tick();
      n_cmp++;
      if (Seg !== 8'h80) begin
        n_bad++;
        $display("FAIL latch_edge j=%0d: Seg=%h, required 80", j, Seg);
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // PWM counter and prescaler start together and 8 is a multiple of 4, so the
  // PWM count during slot cycle p is p mod 4.
  task automatic test_pwm();
    logic [3:0] oh, exp_en;
    int d, p, lit_cnt;
    Val = 16'h1234; BlankLz = 1'b0; Enable = 1'b1;
    for (int b = 0; b < 2; b++) begin
      Brightness = 2'(b);
      wait_frame();
      lit_cnt = 0;
      for (int j = 1; j <= 32; j++) begin
        tick();
        d = (j - 1) / 8;
        p = (j - 1) % 8;
        oh = 4'b0001 << d;
        exp_en = (p != 0 && (p % 4) <= b) ? ~oh : 4'hF;
        if (Seg_En !== 4'hF) lit_cnt++;
        n_cmp++;
        if (Seg_En !== exp_en) begin
          n_bad++;
          $display("FAIL pwm_en br=%0d j=%0d: Seg_En=%b, required %b", b, j, Seg_En, exp_en);
        end
      end
      n_cmp++;
      if (lit_cnt != ((b == 0) ? 4 : 12)) begin
        n_bad++;
        $display("FAIL pwm_count br=%0d: lit cycles=%0d, required %0d", b, lit_cnt, (b == 0) ? 4 : 12);
      end
    end
    Brightness = 2'd3;
    Enable = 1'b0;
    wait_frame();
    for (int j = 1; j <= 32; j++) begin
      tick();
      n_cmp++;
      if (Seg_En !== 4'hF) begin
        n_bad++;
        $display("FAIL enable_off j=%0d: Seg_En=%b, required 1111", j, Seg_En);
      end
    end
    Enable = 1'b1;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset_mid();
    logic [3:0] oh, exp_en;
    int d, p;
    Val = 16'h1234; BlankLz = 1'b0;
    wait_frame();
    for (int j = 1; j <= 18; j++) tick();
    n_cmp++;
    if (DigitIdx !== 2'd2) begin
      n_bad++;
      $display("FAIL mid_pre_idx: DigitIdx=%0d, required 2", DigitIdx);
    end
    for (int pass = 0; pass < 2; pass++) begin
      BlankLz = (pass == 1);
      Reset = 1'b1;
      tick();
      n_cmp++;
      if (Seg !== 8'hFF || Seg_En !== 4'hF || DigitIdx !== 2'd0 || FrameTick !== 1'b0) begin
        n_bad++;
        $display("FAIL mid_reset pass=%0d: Seg=%h Seg_En=%h DigitIdx=%0d FrameTick=%b, required FF F 0 0",
                 pass, Seg, Seg_En, DigitIdx, FrameTick);
      end
      Reset = 1'b0;
      for (int n = 1; n <= 32; n++) begin
        tick();
        d = (n - 1) / 8;
        p = (n - 1) % 8;
        oh = 4'b0001 << d;
        exp_en = (p == 0 || (pass == 1 && d > 0)) ? 4'hF : ~oh;
        n_cmp++;
        if (Seg_En !== exp_en) begin
          n_bad++;
          $display("FAIL mid_after_en pass=%0d n=%0d: Seg_En=%b, required %b", pass, n, Seg_En, exp_en);
        end
        if (pass == 0 || d == 0) begin
          n_cmp++;
          if (Seg !== 8'hC0) begin
            n_bad++;
            $display("FAIL mid_after_seg pass=%0d n=%0d: Seg=%h, required C0", pass, n, Seg);
          end
        end
        if (n == 32) begin
          n_cmp++;
          if (FrameTick !== 1'b1) begin
            n_bad++;
            $display("FAIL mid_after_tick pass=%0d: FrameTick=%b, required 1", pass, FrameTick);
          end
        end
      end
    end
    BlankLz = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset_on_wrap();
    // Positioned at j = 0; move to j = 31 so the next edge would be the wrap.
    for (int j = 1; j <= 31; j++) tick();
    Reset = 1'b1;
    tick();
    n_cmp++;
    if (FrameTick !== 1'b0 || DigitIdx !== 2'd0 || Seg !== 8'hFF || Seg_En !== 4'hF) begin
      n_bad++;
      $display("FAIL wrap_reset: FrameTick=%b DigitIdx=%0d Seg=%h Seg_En=%h, required 0 0 FF F",
               FrameTick, DigitIdx, Seg, Seg_En);
    end
    Reset = 1'b0;
    for (int n = 1; n <= 3; n++) tick();
    n_cmp++;
    if (Seg !== 8'hC0 || Seg_En !== 4'b1110) begin
      n_bad++;
      $display("FAIL wrap_reset_shadow: Seg=%h Seg_En=%b, required C0 1110", Seg, Seg_En);
    end
  endtask

  initial begin
    test_reset();
    test_decode();
    test_decimal_point();
    test_blank_lz();
    test_frame_latch();
    test_pwm();
    test_reset_mid();
    test_reset_on_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
